// File: rtl/chunked_add_sequencer_pkg.sv
// chunked_add_sequencer_pkg: shared defaults, FSM encoding and index-width helper
package chunked_add_sequencer_pkg;
   localparam int N_DEF = 8;
   localparam int K_DEF = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   function automatic int idx_w(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction
endpackage

// File: rtl/chunked_add_sequencer_ripple_chunk_adder.sv
// ripple_chunk_adder: combinational N-bit ripple adder built from full-adder cells
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module ripple_chunk_adder #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         cin_i,
   output logic [N-1:0] sum_o,
   output logic         cout_o
);
   logic [N:0] c;
   assign c[0] = cin_i;
   assign cout_o = c[N];
   for (genvar i = 0; i < N; i++) begin : g_fa
      full_adder u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(sum_o[i]), .c_o(c[i+1]));
   end
endmodule

// File: rtl/chunked_add_sequencer.sv
// chunked_add_sequencer: W-bit add/sub computed one N-bit chunk per cycle, LSB first
module chunked_add_sequencer
   import chunked_add_sequencer_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int K = K_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N*K-1:0] a,
   input  logic [N*K-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N*K-1:0] sum,
   output logic         cout,
   output logic         ovf,
   output logic         busy
);
   localparam int W  = N * K;
   localparam int IW = idx_w(K);
   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
   logic [N-1:0]   ch_sum;
   logic           ch_cout;
   ripple_chunk_adder #(.N(N)) u_add (
      .a_i   (opa_q[int'(idx_q)*N +: N]),
      .b_i   (opb_q[int'(idx_q)*N +: N]),
      .cin_i (carry_q),
      .sum_o (ch_sum),
      .cout_o(ch_cout)
   );
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   // Next state: latch operands on acceptance, fold one chunk per RUN cycle, hold result in DONE
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (in_valid) begin
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub;
            idx_d   = '0;
            sum_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            sum_d[int'(idx_q)*N +: N] = ch_sum;
            carry_d = ch_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == IW'(K-1)) begin
               cout_d  = ch_cout;
               ovf_d   = (opa_q[W-1] == opb_q[W-1]) && (ch_sum[N-1] != opa_q[W-1]);
               state_d = DONE;
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: doc/chunked_add_sequencer.md
Name: chunked_add_sequencer

Overview:
- Multi-precision adder/subtractor controller that time-multiplexes one N-bit ripple chunk adder over K chunks, giving a W=N*K-bit result.
- Operands are accepted through a valid/ready handshake and processed LSB chunk first, one chunk per cycle, with the carry held in a register between chunks.
- The result is presented through a valid/ready output handshake.
- Used wherever wide add/sub is needed but area forbids a full-width ripple chain.

Parameters:
- N, 8, chunk width in bits (>=1).
- K, 4, number of chunks (>=2); W = N*K.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A (unsigned or two's complement).
- b  input  W  operand B.
- sub  input  1  0: A+B; 1: A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  W  result.
- cout  output  1  carry out of bit W-1 (for sub: 1 = no borrow).
- ovf  output  1  signed overflow.
- busy  output  1  high in RUN and DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset: state=IDLE, chunk index=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1 in the cycle after rst is sampled high. The operand registers reset to 0.
- rst overrides everything. Asserting rst mid-RUN or in DONE discards the operation and emits no out_valid.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a into opA, latch (sub ? ~b : b) into opB, carry<=sub, idx<=0, sum<=0, then go to RUN.
  - sub is sampled only at acceptance.
- RUN:
  - in_ready=0.
  - Chunk adder inputs: opA[idx*N +: N], opB[idx*N +: N], carry.
  - Each cycle: sum[idx*N +: N] <= chunk sum; carry <= chunk cout; idx <= idx+1.
  - On the cycle idx==K-1: cout <= chunk cout; ovf <= (opA[W-1]==opB[W-1]) && (chunk sum MSB != opA[W-1]); go to DONE.
- DONE:
  - out_valid=1. sum, cout and ovf are stable and held.
  - in_ready=0; in_valid is ignored.
  - On out_ready: out_valid falls next cycle, state goes to IDLE.
  - sum, cout and ovf keep their values until the next acceptance.
- Latency: with an acceptance edge at T, out_valid is high from T+K through the handshake edge.
- Minimum spacing between acceptances is K+2 cycles. There is no DONE->RUN bypass.
- Wrap-around: all arithmetic is modulo 2^W. The carry from the final chunk goes only to cout and is never fed back.
- idx width is clog2(K). idx returns to 0 on entering RUN, so no overflow is possible.
- out_valid must not depend combinationally on out_ready. in_ready must not depend on in_valid.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE/RUN/DONE.
  - IDX_W = clog2(K) helper.
  - Default N/K constants.
- Sub-module ripple_chunk_adder:
  - Purely combinational N-bit ripple adder with cin, sum and cout, built from the team full-adder cell.
  - The controller instantiates exactly one.

Test Plan (N=8, K=4 unless stated):
- Add, simple carry: a=0x000000FF, b=0x00000001, sub=0 -> sum=0x00000100, cout=0, ovf=0; out_valid rises exactly 4 cycles after the acceptance edge.
- Full-width carry propagation: a=0xFFFFFFFF, b=0x00000001, sub=0 -> sum=0x00000000, cout=1, ovf=0.
- Subtract with borrow: a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
- Signed overflow: a=0x7FFFFFFF, b=1, sub=0 -> sum=0x80000000, ovf=1, cout=0. Then a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and changing a/b/sub -> sum/cout/ovf stable, in_ready=0, nothing accepted. Raise out_ready -> out_valid low next cycle, in_ready high; next operand computes correctly.
- Reset mid-operation: assert rst for 1 cycle after 2 chunks of RUN -> next cycle out_valid=0, sum=0, busy=0, in_ready=1; no result ever appears for the aborted op; the following op (0x12345678+0x11111111) gives 0x23456789.
